shift_add_mult: RTL and testbench
=================================

SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: start  input  1  request a new multiplication; sampled only in IDLE or DONE.
REQ-005 SHALL have port: signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 SHALL have port: a  input  WIDTH  multiplicand; sampled with start.
REQ-007 SHALL have port: b  input  WIDTH  multiplier; sampled with start.
REQ-008 SHALL have port: busy  output  1  high in CALC and FIX.
REQ-009 SHALL have port: done  output  1  high in DONE; held until the next accepted start or rst.
REQ-010 SHALL have port: product  output  2*WIDTH  result; valid while done=1.

Function
REQ-011 SHALL implement a four-state FSM: IDLE, CALC, FIX, DONE.
REQ-012 In IDLE or DONE, an edge with start=1 SHALL capture signed_mode, sign flag (a_msb XOR b_msb when signed_mode=1, else 0), magnitude of a into a 2*WIDTH shift register A, magnitude of b into WIDTH register B, and clear accumulator P to 0.
REQ-013 Magnitude SHALL be the operand itself when unsigned or non-negative, else its two's-complement negation taken as WIDTH-bit unsigned (-2^(WIDTH-1) gives 2^(WIDTH-1)).
REQ-014 The capturing edge SHALL go to CALC if |b| is non-zero, else directly to FIX.
REQ-015 Each CALC edge: P <= P + A if B[0]=1; A <= A<<1; B <= B>>1.
REQ-016 CALC SHALL go to FIX on the edge where the shifted B becomes zero (early exit); at most WIDTH CALC edges.
REQ-017 FIX edge: product <= sign ? -P : P (mod 2^(2*WIDTH)); state -> DONE.
REQ-018 Latency: with n = bit length of |b| (0 for b=0), done SHALL rise after edge E0+n+1, where E0 is the start-capturing edge; maximum WIDTH+1 edges.
REQ-019 start SHALL be ignored in CALC and FIX; operand inputs SHALL be ignored outside the capturing edge.
REQ-020 start in DONE SHALL begin a new operation on that edge: done deasserts, busy asserts (or FIX entered) on the same edge.
REQ-021 product SHALL hold its last value from FIX until the next FIX; it is not cleared by start.
REQ-022 Accumulation SHALL be 2*WIDTH bits wide with no overflow for any legal operand pair.
REQ-023 busy and done SHALL be decoded from registered state only (glitch-free, never high together).

Reset
REQ-024 rst=1 at an edge SHALL force IDLE, busy=0, done=0, product=0, P=0, A=0, B=0, sign flag=0, regardless of state, including mid-CALC.
REQ-025 rst SHALL take priority over start on the same edge; start is accepted only on the first edge after rst falls, if still high.

Verification
REQ-026 WIDTH=8, unsigned, a=13, b=11, start one cycle -> busy for 5 edges, done after E0+5, product=143 (0x008F).
REQ-027 WIDTH=8, unsigned, a=255, b=255 -> done after E0+9, product=0xFE01; a=200, b=0 -> done after E0+1, product=0.
REQ-028 WIDTH=8, signed, a=0xFD (-3), b=5 -> product=0xFFF1 (-15); a=0x80, b=0x80 -> product=0x4000; a=0x80, b=0x01 -> product=0xFF80.
REQ-029 Start pulsed again at E0+2 while busy with new operands -> ignored, original product produced; then start held in DONE -> new operation begins, done low on that edge.
REQ-030 rst asserted at E0+3 of an 8-cycle operation -> next edge IDLE, busy=0, done=0, product=0; subsequent start gives correct result.
REQ-031 Random regression (>=1000 operations, WIDTH=4, 8, 16, both modes) -> product equals reference a*b modulo 2^(2*WIDTH) and latency matches REQ-018.

Source files
------------

// File: rtl/shift_add_mult.sv
// shift_add_mult: sequential sign-magnitude shift-and-add multiplier.
// Multiplies operand magnitudes, exits early once the multiplier runs out of ones, then applies the sign.
module shift_add_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state_q, state_d;
  logic sign_q, sign_d;
  logic [2*WIDTH-1:0] a_q, a_d, p_q, p_d, product_q, product_d;
  logic [WIDTH-1:0] b_q, b_d, a_mag, b_mag;
  logic accept;
  always_comb begin
    a_mag = (signed_mode && a[WIDTH-1]) ? -a : a;
    b_mag = (signed_mode && b[WIDTH-1]) ? -b : b;
    accept = start && (state_q == IDLE || state_q == DONE);
    state_d = state_q;
    sign_d = sign_q;
    a_d = a_q;
    b_d = b_q;
    p_d = p_q;
    product_d = product_q;
    if (accept) begin
      sign_d = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
      a_d = {{WIDTH{1'b0}}, a_mag};
      b_d = b_mag;
      p_d = '0;
      state_d = (b_mag != '0) ? CALC : FIX;
    end else if (state_q == CALC) begin
      p_d = b_q[0] ? p_q + a_q : p_q;
      a_d = a_q << 1;
      b_d = b_q >> 1;
      // leave as soon as no multiplier ones remain
      state_d = (b_q[WIDTH-1:1] == '0) ? FIX : CALC;
    end else if (state_q == FIX) begin
      product_d = sign_q ? -p_q : p_q;
      state_d = DONE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sign_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      p_q <= '0;
      product_q <= '0;
    end else begin
      state_q <= state_d;
      sign_q <= sign_d;
      a_q <= a_d;
      b_q <= b_d;
      p_q <= p_d;
      product_q <= product_d;
    end
  end
  assign busy = (state_q == CALC) || (state_q == FIX);
  assign done = (state_q == DONE);
  assign product = product_q;
endmodule

// File: tb/tb_shift_add_mult.sv
// tb_shift_add_mult: directed vectors and random regression for WIDTH 4, 8 and 16 instances sharing one stimulus bus.
module tb_shift_add_mult;
  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, mode = 1'b0;
  logic [15:0] a_bus = '0, b_bus = '0;
  logic busy4, done4, busy8, done8, busy16, done16;
  logic [7:0] p4;
  logic [15:0] p8;
  logic [31:0] p16;
  int n_chk = 0, n_fail = 0;
  int lat[3];
  int wv[3] = '{4, 8, 16};

  always #5 clk = ~clk;

  shift_add_mult #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .start(start), .signed_mode(mode),
    .a(a_bus[3:0]), .b(b_bus[3:0]), .busy(busy4), .done(done4), .product(p4));
  shift_add_mult #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .start(start), .signed_mode(mode),
    .a(a_bus[7:0]), .b(b_bus[7:0]), .busy(busy8), .done(done8), .product(p8));
  shift_add_mult #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .start(start), .signed_mode(mode),
    .a(a_bus), .b(b_bus), .busy(busy16), .done(done16), .product(p16));

  always @(negedge clk)
    if ((busy4 && done4) || (busy8 && done8) || (busy16 && done16)) begin
      n_fail++;
      $display("FAIL busy_done_overlap at %0t", $time);
    end

  typedef struct {
    bit m;
    logic [7:0] a, b;
    longint exp_p;
    int exp_lat;
  } vec_t;
  vec_t vecs[6];

  function automatic longint prod_of(int i);
    return i == 0 ? longint'(p4) : i == 1 ? longint'(p8) : longint'(p16);
  endfunction

  function automatic bit done_of(int i);
    return i == 0 ? done4 : i == 1 ? done8 : done16;
  endfunction

  function automatic longint val(int w, bit m, logic [15:0] x);
    longint v = longint'(x) & ((longint'(1) << w) - 1);
    if (m && x[w-1]) v -= longint'(1) << w;
    return v;
  endfunction

  function automatic longint ref_prod(int w, bit m, logic [15:0] x, logic [15:0] y);
    return (val(w, m, x) * val(w, m, y)) & ((longint'(1) << (2 * w)) - 1);
  endfunction

  function automatic int ref_lat(int w, bit m, logic [15:0] y);
    longint mag = val(w, m, y);
    int n = 0;
    if (mag < 0) mag = -mag;
    while (mag > 0) begin
      n++;
      mag = mag >> 1;
    end
    return n + 1;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic collect(input int k0);
    for (int i = 0; i < 3; i++) lat[i] = 0;
    for (int k = k0 + 1; k <= k0 + 40 && (lat[0] == 0 || lat[1] == 0 || lat[2] == 0); k++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) if (lat[i] == 0 && done_of(i)) lat[i] = k;
    end
  endtask

  task automatic launch(input bit m, input logic [15:0] x, input logic [15:0] y);
    mode = m; a_bus = x; b_bus = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic check_all(input string nm, input bit m, input logic [15:0] x, input logic [15:0] y);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_w%0d_prod", nm, wv[i]), prod_of(i), ref_prod(wv[i], m, x, y));
      chk($sformatf("%s_w%0d_lat", nm, wv[i]), lat[i], ref_lat(wv[i], m, y));
    end
  endtask

  initial begin
    vecs[0] = '{1'b0, 8'd13, 8'd11, 64'h008F, 5};
    vecs[1] = '{1'b0, 8'd255, 8'd255, 64'hFE01, 9};
    vecs[2] = '{1'b0, 8'd200, 8'd0, 64'h0000, 1};
    vecs[3] = '{1'b1, 8'hFD, 8'd5, 64'hFFF1, 4};
    vecs[4] = '{1'b1, 8'h80, 8'h80, 64'h4000, 9};
    vecs[5] = '{1'b1, 8'h80, 8'h01, 64'hFF80, 2};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_prod8", p8, 0);
    chk("rst_prod16", p16, 0);
    rst = 1'b0;

    foreach (vecs[j]) begin
      launch(vecs[j].m, {8'h00, vecs[j].a}, {8'h00, vecs[j].b});
      collect(0);
      chk($sformatf("vec%0d_prod", j), prod_of(1), vecs[j].exp_p);
      chk($sformatf("vec%0d_lat", j), lat[1], vecs[j].exp_lat);
    end

    launch(1'b0, 16'd13, 16'd11);
    chk("busy_after_start", busy8, 1);
    @(posedge clk); #1;
    start = 1'b1; a_bus = 16'd1; b_bus = 16'd1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_ignore_start", busy8, 1);
    collect(2);
    chk("ignore_prod", prod_of(1), 143);
    chk("ignore_lat", lat[1], 5);
    launch(1'b0, 16'd3, 16'd4);
    chk("restart_done_low", done8, 0);
    chk("restart_busy", busy8, 1);
    chk("restart_prod_held", prod_of(1), 143);
    collect(0);
    check_all("restart", 1'b0, 16'd3, 16'd4);

    launch(1'b0, 16'd255, 16'd255);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", busy8, 0);
    chk("midrst_done", done8, 0);
    chk("midrst_prod", p8, 0);
    rst = 1'b0;
    launch(1'b1, 16'hFFFD, 16'h0007);
    collect(0);
    check_all("after_rst", 1'b1, 16'hFFFD, 16'h0007);

    rst = 1'b1; start = 1'b1; a_bus = 16'd2; b_bus = 16'd3; mode = 1'b0;
    @(posedge clk); #1;
    chk("rst_prio_busy", busy8, 0);
    chk("rst_prio_done", done8, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("post_rst_accept", busy8, 1);
    collect(0);
    check_all("post_rst", 1'b0, 16'd2, 16'd3);

    for (int r = 0; r < 1000; r++) begin
      logic [15:0] x, y;
      bit m;
      x = 16'($urandom);
      y = 16'($urandom);
      case ($urandom_range(0, 3))
        0: y = 16'h0000;
        1: y = y & 16'h000F;
        default: ;
      endcase
      m = 1'($urandom);
      launch(m, x, y);
      collect(0);
      check_all($sformatf("rnd%0d", r), m, x, y);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
